lsu_mem_access: RTL and testbench

//  Load/store unit downstream of the control decoder in the RISC-V core.

---
 rtl/lsu_mem_access.sv | 189 ++++++++++++++++++
 tb/tb_lsu_mem_access.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_access.sv
// Load/store unit: runs one req/ack data-memory transaction per load/store and
// stalls the core until it completes, faults or times out.
module lsu_mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_wr,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic        we_r;
  logic [2:0]  op_r;
  logic [1:0]  off_r;
  logic [31:0] cnt_r;
  logic        fault_s;
  logic        tmo_hit_s;

  // Illegal op for the direction, or address not aligned to the access size.
  function automatic logic op_fault(input logic wr, input logic [2:0] op, input logic [1:0] o);
    logic bad;
    case (op)
      3'b000:  bad = (o != 2'b00);
      3'b001:  bad = 1'b0;
      3'b010:  bad = o[0];
      3'b101:  bad = wr;
      3'b110:  bad = wr | o[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_strb(input logic [2:0] op, input logic [1:0] o);
    logic [3:0] s;
    case (op[1:0])
      2'b00:   s = 4'b1111;
      2'b01:   s = 4'b0001 << o;
      2'b10:   s = o[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] op, input logic [31:0] d);
    logic [31:0] r;
    case (op[1:0])
      2'b01:   r = {4{d[7:0]}};
      2'b10:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] o,
                                              input logic [31:0] d);
    logic [31:0] sb, sh, r;
    sb = d >> {o, 3'b000};
    sh = d >> {o[1], 4'b0000};
    case (op)
      3'b000:  r = d;
      3'b001:  r = {{24{sb[7]}}, sb[7:0]};
      3'b010:  r = {{16{sh[15]}}, sh[15:0]};
      3'b101:  r = {24'd0, sb[7:0]};
      3'b110:  r = {16'd0, sh[15:0]};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign fault_s = op_fault(mem_wr, mem_op, addr[1:0]);
  assign stall   = start & (state_r != DONE);

  // Abort condition: the last permitted REQ cycle passes without an ack.
  always_comb begin
    tmo_hit_s = 1'b0;
    if (TIMEOUT > 0) begin
      tmo_hit_s = (cnt_r == 32'(TIMEOUT - 1));
    end else begin
      tmo_hit_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = fault_s ? DONE : REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (bus_ack || tmo_hit_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = REQ;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered bus outputs, latched access attributes and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      rdata     <= 32'd0;
      misalign  <= 1'b0;
      timeout   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wstrb <= 4'd0;
      bus_wdata <= 32'd0;
      we_r      <= 1'b0;
      op_r      <= 3'd0;
      off_r     <= 2'd0;
      cnt_r     <= 32'd0;
    end else begin
      done    <= (state_nxt_s == DONE);
      bus_req <= (state_nxt_s == REQ);
      case (state_r)
        IDLE: begin
          if (start) begin
            we_r      <= mem_wr;
            op_r      <= mem_op;
            off_r     <= addr[1:0];
            bus_we    <= mem_wr;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_wstrb <= (mem_wr && !fault_s) ? lane_strb(mem_op, addr[1:0]) : 4'b0000;
            bus_wdata <= lane_wdata(mem_op, wdata);
            misalign  <= fault_s;
            timeout   <= 1'b0;
            cnt_r     <= 32'd0;
          end
        end
        REQ: begin
          if (bus_ack) begin
            if (!we_r) begin
              rdata <= load_extend(op_r, off_r, bus_rdata);
            end
          end else if (tmo_hit_s) begin
            timeout <= 1'b1;
            rdata   <= 32'd0;
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Randomized scoreboard bench for lsu_mem_access: a driver issues accesses, a
// bus responder checks the bus side and a done monitor checks results.
module tb_lsu_mem_access;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mem_wr;
  logic [2:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  logic        timeout;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  lsu_mem_access #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_wr(mem_wr), .mem_op(mem_op),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
    .misalign(misalign), .timeout(timeout), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mis;
    logic        tmo;
    logic [31:0] rd;
    bit          chk_rd;
    int          lat;
    int          start_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wd;
    int          delay;
    bit          noack;
    bit          abort;
    logic [31:0] rd;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   last_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_legal(input bit wr, input logic [2:0] op);
    if (wr) return op inside {3'd0, 3'd1, 3'd2};
    return op inside {3'd0, 3'd1, 3'd2, 3'd5, 3'd6};
  endfunction

  function automatic int m_size(input logic [2:0] op);
    if (op[1:0] == 2'd0) return 4;
    if (op[1:0] == 2'd1) return 1;
    return 2;
  endfunction

  function automatic bit m_fault(input bit wr, input logic [2:0] op, input logic [31:0] a);
    return !m_legal(wr, op) || ((int'(a[1:0]) % m_size(op)) != 0);
  endfunction

  function automatic logic [3:0] m_strb(input bit wr, input logic [2:0] op, input logic [31:0] a);
    int sz = m_size(op);
    if (!wr) return 4'b0000;
    return 4'(((1 << sz) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] d);
    logic [31:0] r = 32'd0;
    int sz = m_size(op);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] word);
    int sz = m_size(op);
    logic [31:0] w = word >> (8 * int'(a[1:0]));
    logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    logic [31:0] v = w & mask;
    if (op < 3'd4 && sz < 4 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic run(input bit wr, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] wd, input int dly, input bit noack,
                     input logic [31:0] brd);
    exp_t e;
    bus_t b;
    bit   f = m_fault(wr, op, a);
    bit   seen = 1'b0;
    int   waited = 0;
    e.start_cyc = last_done ? cyc + 1 : cyc;
    e.mis = f;
    e.tmo = 1'b0;
    e.rd = 32'd0;
    e.chk_rd = 1'b0;
    if (f) begin
      e.lat = 1;
    end else if (noack) begin
      e.lat = TMO + 1;
      e.tmo = 1'b1;
      e.chk_rd = 1'b1;
    end else begin
      e.lat = 2 + dly;
      e.chk_rd = !wr;
      e.rd = m_rdata(op, a, brd);
    end
    exp_q.push_back(e);
    if (!f) begin
      b.addr = {a[31:2], 2'b00};
      b.we = wr;
      b.strb = m_strb(wr, op, a);
      b.wd = m_wdata(op, wd);
      b.delay = dly;
      b.noack = noack;
      b.abort = 1'b0;
      b.rd = brd;
      bus_q.push_back(b);
    end
    start = 1'b1;
    mem_wr = wr;
    mem_op = op;
    addr = a;
    wdata = wd;
    while (!seen && waited < 60) begin
      @(negedge clk);
      waited++;
      if (done) seen = 1'b1;
      else chk("stall_busy", {31'd0, stall}, 32'd1);
    end
    if (!seen) begin
      flag("done_never_arrived");
      exp_q.delete();
      bus_q.delete();
    end else begin
      chk("stall_in_done", {31'd0, stall}, 32'd0);
    end
    last_done = seen;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    mem_op = 3'($urandom_range(0, 7));
    addr = $urandom;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_no_req", {31'd0, bus_req}, 32'd0);
      chk("idle_no_stall", {31'd0, stall}, 32'd0);
    end
    if (n > 0) last_done = 1'b0;
  endtask

  // ---------------- done monitor ----------------
  exp_t me;
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        flag("unexpected_done");
      end else begin
        me = exp_q.pop_front();
        chk("latency", 32'(cyc - me.start_cyc), 32'(me.lat));
        chk("misalign", {31'd0, misalign}, {31'd0, me.mis});
        chk("timeout", {31'd0, timeout}, {31'd0, me.tmo});
        if (me.chk_rd) chk("rdata", rdata, me.rd);
      end
    end
  end

  // ---------------- bus responder ----------------
  bus_t cur;
  bit   in_txn = 1'b0;
  int   nreq = 0;
  initial begin
    bus_ack = 1'b0;
    bus_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!in_txn && bus_req) begin
        if (bus_q.size() == 0) begin
          flag("unexpected_bus_req");
        end else begin
          cur = bus_q.pop_front();
          in_txn = 1'b1;
          nreq = 0;
        end
      end
      if (in_txn) begin
        if (bus_req) begin
          nreq++;
          chk("bus_addr", bus_addr, cur.addr);
          chk("bus_we", {31'd0, bus_we}, {31'd0, cur.we});
          chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, cur.strb});
          if (cur.we) chk("bus_wdata", bus_wdata, cur.wd);
          if (!cur.noack && nreq > cur.delay + 1) flag("bus_req_held_after_ack");
          if (!cur.noack && nreq == cur.delay + 1) begin
            bus_ack = 1'b1;
            bus_rdata = cur.rd;
          end else begin
            bus_ack = 1'b0;
            bus_rdata = $urandom;
          end
        end else begin
          in_txn = 1'b0;
          bus_ack = 1'b0;
          if (cur.noack && !cur.abort) chk("req_cycles", 32'(nreq), 32'(TMO));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus_t ab;
    rst_n = 1'b0;
    start = 1'b0;
    mem_wr = 1'b0;
    mem_op = 3'd0;
    addr = 32'd0;
    wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_flags", {30'd0, misalign, timeout}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // directed scenarios
    run(1'b0, 3'b000, 32'h0000_0100, 32'd0, 0, 1'b0, 32'hDEAD_BEEF);
    idle(1);
    run(1'b0, 3'b001, 32'h0000_0103, 32'd0, 0, 1'b0, 32'h8000_0000);
    run(1'b0, 3'b101, 32'h0000_0103, 32'd0, 1, 1'b0, 32'h8000_0000);
    idle(1);
    run(1'b1, 3'b010, 32'h0000_0202, 32'h1234_ABCD, 3, 1'b0, 32'd0);
    idle(1);
    run(1'b0, 3'b000, 32'h0000_0101, 32'd0, 0, 1'b0, 32'd0);
    run(1'b1, 3'b101, 32'h0000_0200, 32'h5555_AAAA, 0, 1'b0, 32'd0);
    idle(1);
    run(1'b0, 3'b000, 32'h0000_0400, 32'd0, 0, 1'b1, 32'd0);
    idle(1);

    // reset while the request is outstanding
    ab.addr = 32'h0000_0300;
    ab.we = 1'b0;
    ab.strb = 4'b0000;
    ab.wd = 32'd0;
    ab.delay = 0;
    ab.noack = 1'b1;
    ab.abort = 1'b1;
    ab.rd = 32'd0;
    bus_q.push_back(ab);
    start = 1'b1;
    mem_wr = 1'b0;
    mem_op = 3'b000;
    addr = 32'h0000_0300;
    repeat (3) @(negedge clk);
    chk("req_before_reset", {31'd0, bus_req}, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("reset_drops_req", {31'd0, bus_req}, 32'd0);
    chk("reset_no_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_done = 1'b0;
    idle(1);
    run(1'b0, 3'b000, 32'h0000_0500, 32'd0, 1, 1'b0, 32'hCAFE_F00D);
    run(1'b1, 3'b000, 32'h0000_0504, 32'h0BAD_F00D, 0, 1'b0, 32'd0);
    run(1'b0, 3'b000, 32'h0000_0504, 32'd0, 0, 1'b0, 32'h0BAD_F00D);
    idle(1);

    // randomized accesses, random gaps including back-to-back
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 1) == 0) a[0] = 1'b0;
      run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
          $urandom_range(0, 4), $urandom_range(0, 19) == 0, $urandom);
      idle($urandom_range(0, 2));
    end

    idle(4);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_time_limit (cycle %0d)", cyc);
    $fatal(1, "time limit");
  end

endmodule
